// File: rtl/dm_sba_ctrl.sv
// System-bus access engine: turns sbaddress/sbdata CSR events into single lane-steered
// bus transactions, with size/alignment pre-checks, bus-error reporting and a response timeout.
module dm_sba_ctrl #(
    parameter int BusWidth      = 32,
    parameter int TimeoutCycles = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dmactive_i,
    input  logic [BusWidth-1:0]   sbaddress_i,
    input  logic                  sbaddress_write_valid_i,
    output logic [BusWidth-1:0]   sbaddress_o,
    input  logic                  sbreadonaddr_i,
    input  logic                  sbreadondata_i,
    input  logic                  sbautoincrement_i,
    input  logic [2:0]            sbaccess_i,
    input  logic [BusWidth-1:0]   sbdata_i,
    input  logic                  sbdata_write_valid_i,
    input  logic                  sbdata_read_valid_i,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  sbdata_valid_o,
    output logic                  sbbusy_o,
    output logic                  sberror_valid_o,
    output logic [2:0]            sberror_o,
    output logic                  master_req_o,
    output logic [BusWidth-1:0]   master_add_o,
    output logic                  master_we_o,
    output logic [BusWidth-1:0]   master_wdata_o,
    output logic [BusWidth/8-1:0] master_be_o,
    input  logic                  master_gnt_i,
    input  logic                  master_r_valid_i,
    input  logic [BusWidth-1:0]   master_r_rdata_i,
    input  logic                  master_r_err_i
);
    localparam int NB    = BusWidth / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    typedef enum logic [2:0] {IDLE, READ, WRITE, WAIT_READ, WAIT_WRITE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          access;
    logic [BusWidth-1:0] eff_addr;
    logic [OFF_W-1:0]    off;
    logic                start_write;
    logic                start_read;
    logic                size_bad;
    logic                misaligned;
    logic                timeout_hit;

    function automatic logic [NB-1:0] size_mask(input logic [2:0] acc);
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++) m[i] = (i < (1 << acc));
        return m;
    endfunction

    function automatic logic [BusWidth-1:0] byte_expand(input logic [NB-1:0] be);
        logic [BusWidth-1:0] m;
        for (int i = 0; i < NB; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    assign off         = sbaddress_o[OFF_W-1:0];
    assign sbbusy_o    = (state != IDLE);
    assign timeout_hit = (TimeoutCycles != 0) && (cnt == CNT_W'(TimeoutCycles - 1));

    // A same-cycle address write supplies the address for whichever trigger wins.
    always_comb begin
        eff_addr    = sbaddress_write_valid_i ? sbaddress_i : sbaddress_o;
        start_write = sbdata_write_valid_i;
        start_read  = !sbdata_write_valid_i &&
                      ((sbaddress_write_valid_i && sbreadonaddr_i) ||
                       (sbdata_read_valid_i && sbreadondata_i));
        size_bad    = (1 << sbaccess_i) > NB;
        misaligned  = |(eff_addr[OFF_W-1:0] & OFF_W'((1 << sbaccess_i) - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !dmactive_i) begin
            state           <= IDLE;
            cnt             <= '0;
            access          <= '0;
            sbaddress_o     <= '0;
            sbdata_o        <= '0;
            sbdata_valid_o  <= 1'b0;
            sberror_valid_o <= 1'b0;
            sberror_o       <= '0;
            master_req_o    <= 1'b0;
            master_add_o    <= '0;
            master_we_o     <= 1'b0;
            master_wdata_o  <= '0;
            master_be_o     <= '0;
        end else begin
            sbdata_valid_o  <= 1'b0;
            sberror_valid_o <= 1'b0;
            cnt             <= cnt + 1'b1;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (sbaddress_write_valid_i) sbaddress_o <= sbaddress_i;
                    if (start_write || start_read) begin
                        if (size_bad) begin
                            sberror_valid_o <= 1'b1;
                            sberror_o       <= 3'd4;
                        end else if (misaligned) begin
                            sberror_valid_o <= 1'b1;
                            sberror_o       <= 3'd3;
                        end else begin
                            state          <= start_write ? WRITE : READ;
                            access         <= sbaccess_i;
                            master_req_o   <= 1'b1;
                            master_we_o    <= start_write;
                            master_add_o   <= eff_addr;
                            master_be_o    <= size_mask(sbaccess_i) << eff_addr[OFF_W-1:0];
                            master_wdata_o <= start_write ?
                                              (sbdata_i << {eff_addr[OFF_W-1:0], 3'b000}) : '0;
                        end
                    end
                end
                READ, WRITE: begin
                    if (master_gnt_i) begin
                        master_req_o <= 1'b0;
                        state        <= (state == READ) ? WAIT_READ : WAIT_WRITE;
                    end else if (timeout_hit) begin
                        master_req_o    <= 1'b0;
                        sberror_valid_o <= 1'b1;
                        sberror_o       <= 3'd1;
                        state           <= IDLE;
                    end
                end
                WAIT_READ, WAIT_WRITE: begin
                    if (master_r_valid_i) begin
                        state <= IDLE;
                        if (master_r_err_i) begin
                            sberror_valid_o <= 1'b1;
                            sberror_o       <= 3'd2;
                        end else begin
                            if (state == WAIT_READ) begin
                                sbdata_o       <= (master_r_rdata_i >> {off, 3'b000}) &
                                                  byte_expand(size_mask(access));
                                sbdata_valid_o <= 1'b1;
                            end
                            if (sbautoincrement_i)
                                sbaddress_o <= sbaddress_o + BusWidth'(32'd1 << access);
                        end
                    end else if (timeout_hit) begin
                        sberror_valid_o <= 1'b1;
                        sberror_o       <= 3'd1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
